// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module   : mem_port_arbiter
//  Function : Shares one single-ported, variable-latency memory between the
//             instruction-fetch and data ports, with a watchdog on the ack.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int FETCH_STARVE = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY_I = 2'd1,
        S_BUSY_D = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0]  c_starve_max = 4'(FETCH_STARVE);
    localparam logic [7:0]  c_wd_last    = 8'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic        c_wd_en      = (TIMEOUT != 0);
    localparam logic [31:0] c_abort_data = 32'hDEAD_BEEF;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_starve_cnt, w_starve_nxt;
    logic [7:0]  r_wd_cnt, w_wd_nxt;
    logic        r_mem_req, w_mem_req_nxt;
    logic        r_mem_we, w_mem_we_nxt;
    logic [31:0] r_mem_addr, w_mem_addr_nxt;
    logic [31:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [31:0] r_if_rdata, w_if_rdata_nxt;
    logic [31:0] r_d_rdata, w_d_rdata_nxt;
    logic        r_if_ready, w_if_ready_nxt;
    logic        r_d_ready, w_d_ready_nxt;
    logic        r_err, w_err_nxt;
    logic        w_grant_i;
    logic        w_grant_d;
    logic        w_complete;
    logic        w_abort;

    always_comb begin
        w_state_nxt     = r_state;
        w_starve_nxt    = r_starve_cnt;
        w_wd_nxt        = r_wd_cnt;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_if_rdata_nxt  = r_if_rdata;
        w_d_rdata_nxt   = r_d_rdata;
        w_if_ready_nxt  = 1'b0;
        w_d_ready_nxt   = 1'b0;
        w_err_nxt       = 1'b0;
        w_grant_i       = 1'b0;
        w_grant_d       = 1'b0;
        w_complete      = 1'b0;
        w_abort         = 1'b0;

        case (r_state)
            S_IDLE: begin
                // A starved fetch outranks data; otherwise data has priority.
                if ((r_starve_cnt == c_starve_max) && if_req) begin
                    w_grant_i = 1'b1;
                end else if (d_req) begin
                    w_grant_d = 1'b1;
                end else if (if_req) begin
                    w_grant_i = 1'b1;
                end

                if (w_grant_i) begin
                    w_state_nxt     = S_BUSY_I;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_addr_nxt  = if_addr;
                    w_mem_wdata_nxt = 32'h0;
                    w_starve_nxt    = 4'd0;
                    w_wd_nxt        = 8'd0;
                end else if (w_grant_d) begin
                    w_state_nxt     = S_BUSY_D;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = d_we;
                    w_mem_addr_nxt  = d_addr;
                    w_mem_wdata_nxt = d_wdata;
                    w_wd_nxt        = 8'd0;
                    if (!if_req) begin
                        w_starve_nxt = 4'd0;
                    end else if (r_starve_cnt != c_starve_max) begin
                        w_starve_nxt = r_starve_cnt + 4'd1;
                    end
                end
            end

            S_BUSY_I, S_BUSY_D: begin
                // An ack arriving on the expiry cycle still completes normally.
                if (mem_ack) begin
                    w_complete = 1'b1;
                end else if (c_wd_en && (r_wd_cnt == c_wd_last)) begin
                    w_abort = 1'b1;
                end else begin
                    w_wd_nxt = r_wd_cnt + 8'd1;
                end

                if (w_complete || w_abort) begin
                    w_state_nxt   = S_DONE;
                    w_mem_req_nxt = 1'b0;
                    w_err_nxt     = w_abort;
                    if (r_state == S_BUSY_I) begin
                        w_if_ready_nxt = 1'b1;
                        w_if_rdata_nxt = w_complete ? mem_rdata : c_abort_data;
                    end else begin
                        w_d_ready_nxt  = 1'b1;
                        w_d_rdata_nxt  = w_complete ? mem_rdata : c_abort_data;
                    end
                end
            end

            default: begin
                // DONE: the requester still holds req this cycle, so never re-grant here.
                w_state_nxt = S_IDLE;
                w_wd_nxt    = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_starve_cnt <= 4'd0;
            r_wd_cnt     <= 8'd0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'h0;
            r_mem_wdata  <= 32'h0;
            r_if_rdata   <= 32'h0;
            r_d_rdata    <= 32'h0;
            r_if_ready   <= 1'b0;
            r_d_ready    <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_wd_cnt     <= w_wd_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_if_rdata   <= w_if_rdata_nxt;
            r_d_rdata    <= w_d_rdata_nxt;
            r_if_ready   <= w_if_ready_nxt;
            r_d_ready    <= w_d_ready_nxt;
            r_err        <= w_err_nxt;
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign if_ready  = r_if_ready;
    assign d_rdata   = r_d_rdata;
    assign d_ready   = r_d_ready;
    assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Function : Directed scenarios plus randomized traffic for mem_port_arbiter,
//             checked every cycle against a transaction-level model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int FS = 4;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;
    logic        err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.FETCH_STARVE(FS), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // owner: 0 = memory free, 1 = fetch access open, 2 = data access open
    int          m_owner = 0;
    bit          m_cooldown = 0;
    int          m_waited = 0;
    int          m_data_streak = 0;
    bit          m_started = 0;
    logic        e_mem_req, e_mem_we, e_if_ready, e_d_ready, e_err;
    logic [31:0] e_mem_addr, e_mem_wdata, e_if_rdata, e_d_rdata;

    always @(posedge clk) begin
        bit          finished;
        logic [31:0] result;
        m_started  = 1'b1;
        e_if_ready = 1'b0;
        e_d_ready  = 1'b0;
        e_err      = 1'b0;
        finished   = 1'b0;
        result     = 32'h0;
        if (reset) begin
            m_owner = 0; m_cooldown = 0; m_waited = 0; m_data_streak = 0;
            e_mem_req = 1'b0; e_mem_we = 1'b0; e_mem_addr = 32'h0; e_mem_wdata = 32'h0;
            e_if_rdata = 32'h0; e_d_rdata = 32'h0;
        end else if (m_cooldown) begin
            m_cooldown = 0;
        end else if (m_owner == 0) begin
            if (if_req && (m_data_streak == FS || !d_req)) begin
                m_owner = 1; m_waited = 0; m_data_streak = 0;
                e_mem_req = 1'b1; e_mem_we = 1'b0; e_mem_addr = if_addr; e_mem_wdata = 32'h0;
            end else if (d_req) begin
                m_owner = 2; m_waited = 0;
                m_data_streak = if_req ? ((m_data_streak + 1 > FS) ? FS : m_data_streak + 1) : 0;
                e_mem_req = 1'b1; e_mem_we = d_we; e_mem_addr = d_addr; e_mem_wdata = d_wdata;
            end
        end else begin
            if (mem_ack) begin
                finished = 1'b1; result = mem_rdata;
            end else if (TO != 0 && m_waited == TO - 1) begin
                finished = 1'b1; result = 32'hDEAD_BEEF; e_err = 1'b1;
            end else begin
                m_waited++;
            end
            if (finished) begin
                if (m_owner == 1) begin e_if_ready = 1'b1; e_if_rdata = result; end
                else              begin e_d_ready  = 1'b1; e_d_rdata  = result; end
                e_mem_req = 1'b0; m_owner = 0; m_cooldown = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("mem_req",   32'(mem_req),  32'(e_mem_req));
            chk("mem_we",    32'(mem_we),   32'(e_mem_we));
            chk("mem_addr",  mem_addr,      e_mem_addr);
            chk("mem_wdata", mem_wdata,     e_mem_wdata);
            chk("if_ready",  32'(if_ready), 32'(e_if_ready));
            chk("d_ready",   32'(d_ready),  32'(e_d_ready));
            chk("err",       32'(err),      32'(e_err));
            chk("if_rdata",  if_rdata,      e_if_rdata);
            chk("d_rdata",   d_rdata,       e_d_rdata);
            chk("ready_excl", 32'(if_ready & d_ready), 32'd0);
        end
    end

    // ---------------- memory responder and requesters ----------------
    bit          rand_mode = 0;
    bit          force_ack = 0;
    int          fixed_lat = 1;
    logic [31:0] fixed_rdata = 32'h0;
    bit          acc_active = 0;
    int          acc_cnt = 0;
    int          acc_lat = 0;

    task automatic pick_lat();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0)      acc_lat = 0;
        else if (r == 1) acc_lat = TO;
        else             acc_lat = int'($urandom_range(1, 4));
    endtask

    task automatic step();
        @(negedge clk);
        if (force_ack) begin
            force_ack = 0; acc_active = 0;
            mem_ack = 1'b1; mem_rdata = fixed_rdata;
        end else if (mem_req) begin
            if (!acc_active) begin
                acc_active = 1; acc_cnt = 0;
                if (rand_mode) pick_lat(); else acc_lat = fixed_lat;
            end
            acc_cnt++;
            mem_ack = (acc_lat != 0 && acc_cnt == acc_lat);
            mem_rdata = rand_mode ? $urandom : fixed_rdata;
        end else begin
            acc_active = 0;
            mem_ack = rand_mode && ($urandom_range(0, 7) == 0);
            mem_rdata = $urandom;
        end
        if (rand_mode) begin
            if (if_ready) if_req = 1'b0;
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = $urandom;
            end
            if (d_ready) d_req = 1'b0;
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
            end
            reset = ($urandom_range(0, 299) == 0);
        end
    endtask

    logic [31:0] grants[$];
    logic        prev_req;
    int          busy_cycles;
    bit          got_ready;

    initial begin
        repeat (3) step();
        chk("rst_mem_req",  32'(mem_req),  32'd0);
        chk("rst_mem_we",   32'(mem_we),   32'd0);
        chk("rst_if_ready", 32'(if_ready), 32'd0);
        chk("rst_d_ready",  32'(d_ready),  32'd0);
        chk("rst_err",      32'(err),      32'd0);
        chk("rst_mem_addr", mem_addr,      32'h0);
        chk("rst_if_rdata", if_rdata,      32'h0);
        chk("rst_d_rdata",  d_rdata,       32'h0);
        reset = 1'b0;
        step();

        // single fetch, ack in first mem_req cycle
        if_req = 1'b1; if_addr = 32'h0000_0040; fixed_lat = 1; fixed_rdata = 32'h2008_0005;
        step();
        chk("sf_c1_mem_req", 32'(mem_req), 32'd1);
        chk("sf_c1_mem_we",  32'(mem_we),  32'd0);
        chk("sf_c1_addr",    mem_addr,     32'h0000_0040);
        chk("sf_c1_d_ready", 32'(d_ready), 32'd0);
        step();
        chk("sf_c2_if_ready", 32'(if_ready), 32'd1);
        chk("sf_c2_if_rdata", if_rdata,      32'h2008_0005);
        chk("sf_c2_model",    e_if_rdata,    32'h2008_0005);
        chk("sf_c2_mem_req",  32'(mem_req),  32'd0);
        if_req = 1'b0;
        step();
        chk("sf_c3_if_ready", 32'(if_ready), 32'd0);

        // store with 3-cycle ack delay
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h54; d_wdata = 32'h7;
        fixed_lat = 3; fixed_rdata = 32'hA5A5_0001;
        for (int c = 1; c <= 3; c++) begin
            step();
            chk("st_mem_req",   32'(mem_req), 32'd1);
            chk("st_mem_we",    32'(mem_we),  32'd1);
            chk("st_mem_addr",  mem_addr,     32'h54);
            chk("st_mem_wdata", mem_wdata,    32'h7);
            chk("st_d_ready_early", 32'(d_ready), 32'd0);
        end
        step();
        chk("st_d_ready", 32'(d_ready), 32'd1);
        chk("st_d_rdata", d_rdata,      32'hA5A5_0001);
        d_req = 1'b0;
        step();
        chk("st_d_ready_once", 32'(d_ready), 32'd0);

        // collision: data first, fetch granted only after DONE
        if_req = 1'b1; if_addr = 32'h2000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000; fixed_lat = 2; fixed_rdata = 32'h1111_2222;
        step();
        chk("col_c1_addr", mem_addr, 32'h1000);
        step();
        step();
        chk("col_c3_d_ready", 32'(d_ready), 32'd1);
        chk("col_c3_mem_req", 32'(mem_req), 32'd0);
        d_req = 1'b0;
        step();
        chk("col_c4_no_grant", 32'(mem_req), 32'd0);
        step();
        chk("col_c5_mem_req", 32'(mem_req), 32'd1);
        chk("col_c5_addr",    mem_addr,     32'h2000);
        step();
        step();
        chk("col_c7_if_ready", 32'(if_ready), 32'd1);
        if_req = 1'b0;
        step();

        // starvation: both held, fetch wins after FS data grants
        if_req = 1'b1; if_addr = 32'h2000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000; fixed_lat = 1;
        prev_req = mem_req;
        for (int c = 0; c < 80 && grants.size() < 6; c++) begin
            step();
            if (mem_req && !prev_req) grants.push_back(mem_addr);
            prev_req = mem_req;
        end
        chk("stv_grant_count", 32'(grants.size()), 32'd6);
        if (grants.size() == 6) begin
            for (int g = 0; g < 4; g++) chk("stv_data_grant", grants[g], 32'h1000);
            chk("stv_fetch_grant", grants[4], 32'h2000);
            chk("stv_after_fetch", grants[5], 32'h1000);
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (4) step();

        // timeout on a data read with no ack
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; fixed_lat = 0;
        busy_cycles = 0; got_ready = 0;
        for (int c = 0; c < 20 && !got_ready; c++) begin
            step();
            if (d_ready) got_ready = 1;
            else if (mem_req) busy_cycles++;
        end
        chk("to_ready_seen", 32'(got_ready), 32'd1);
        chk("to_busy_cycles", 32'(busy_cycles), 32'(TO));
        chk("to_err",     32'(err),     32'd1);
        chk("to_d_rdata", d_rdata,      32'hDEAD_BEEF);
        chk("to_mem_req", 32'(mem_req), 32'd0);
        d_req = 1'b0; force_ack = 1; fixed_rdata = 32'h5555_AAAA;
        step();
        step();
        chk("to_late_ack_ready", 32'(d_ready), 32'd0);
        chk("to_late_ack_err",   32'(err),     32'd0);

        // reset in the middle of a fetch access
        if_req = 1'b1; if_addr = 32'h44; fixed_lat = 0;
        repeat (3) step();
        chk("mr_busy", 32'(mem_req), 32'd1);
        reset = 1'b1;
        step();
        chk("mr_mem_req",  32'(mem_req),  32'd0);
        chk("mr_if_ready", 32'(if_ready), 32'd0);
        chk("mr_d_ready",  32'(d_ready),  32'd0);
        chk("mr_err",      32'(err),      32'd0);
        chk("mr_mem_addr", mem_addr,      32'h0);
        reset = 1'b0; if_req = 1'b0; force_ack = 1;
        step();
        step();
        chk("mr_stale_ack", 32'(if_ready), 32'd0);
        step();
        chk("mr_stale_ack2", 32'(if_ready), 32'd0);

        // randomized traffic
        rand_mode = 1;
        repeat (3000) step();
        rand_mode = 0;
        reset = 1'b0; if_req = 1'b0; d_req = 1'b0; fixed_lat = 1;
        repeat (15) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the pipelined core's instruction-fetch port and its data port.
- Grants one request at a time and drives the memory request/acknowledge handshake.
- Returns read data with a one-cycle ready pulse to the granted requester; requesters stall until they see it.
- Data has priority over fetch, with a bounded-starvation rule for fetch and a watchdog timeout on the memory acknowledge.

Parameters:
- FETCH_STARVE, 4: maximum consecutive data grants made while if_req is pending; the next arbitration must then go to fetch. Range 1–15.
- TIMEOUT, 64: cycles in a BUSY state without mem_ack before the access is aborted. 0 disables the watchdog. Range 0–255.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch read request; held with if_addr until if_ready.
- if_addr  in  32  fetch word address.
- if_rdata  out  32  fetch read data; valid when if_ready=1.
- if_ready  out  1  one-cycle completion pulse to fetch.
- d_req  in  1  data request; held with d_we, d_addr and d_wdata until d_ready.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  32  data word address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data; valid when d_ready=1.
- d_ready  out  1  one-cycle completion pulse to data port.
- mem_req  out  1  memory request; held until mem_ack or abort.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid with mem_ack.
- mem_ack  in  1  memory completion; single cycle; sampled only while mem_req=1.
- err  out  1  one-cycle pulse coincident with the ready pulse of an aborted access.

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, DONE.
- Reset, applied at any time including mid-access:
  - next state IDLE;
  - mem_req, mem_we, if_ready, d_ready and err all 0;
  - mem_addr, mem_wdata, if_rdata and d_rdata all 32'h0;
  - starvation counter and watchdog counter 0.
  - Any outstanding access is dropped; a late mem_ack is ignored.
- IDLE arbitration (grant takes effect at the clock edge):
  - If starve_cnt == FETCH_STARVE and if_req=1: grant fetch.
  - Otherwise, if d_req=1: grant data.
  - Otherwise, if if_req=1: grant fetch.
  - Otherwise stay in IDLE.
- On grant:
  - Register the address, plus we/wdata for data (mem_we=0 and mem_wdata=0 for fetch).
  - Set mem_req=1 and enter BUSY_I or BUSY_D.
- Starvation counter (4-bit):
  - Increments on a data grant while if_req=1, saturating at FETCH_STARVE.
  - Clears on any fetch grant, or on a data grant while if_req=0.
- BUSY_x:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - The watchdog increments each cycle mem_ack=0.
  - On mem_ack=1: capture mem_rdata into x_rdata (captured for writes too), clear mem_req, pulse x_ready next cycle, enter DONE.
  - If TIMEOUT≠0 and the watchdog reaches TIMEOUT-1 with mem_ack=0: clear mem_req, set x_rdata=32'hDEADBEEF, pulse x_ready and err next cycle, enter DONE.
  - If mem_ack arrives in the same cycle the watchdog expires, the ack wins.
- DONE:
  - x_ready (and err on abort) is high for exactly this cycle.
  - Requests are ignored, so the requester's still-high req is not re-granted.
  - Next state is always IDLE; the watchdog clears.
- Hold rule: x_rdata keeps its value until the next completion on that port.
- Latency: request seen in IDLE at cycle 0, mem_req at cycle 1, mem_ack at cycle k≥1 gives x_ready at cycle k+1. Next grant is possible at cycle k+2.
- Simultaneity: if_ready and d_ready are never both 1. mem_ack while mem_req=0 is ignored.
- A requester dropping req while in BUSY is a protocol violation: the access still completes and the ready pulse is still issued.

Test Plan:
- Single fetch:
  - Stimulus: if_req=1, if_addr=32'h0000_0040, memory acks 1 cycle after mem_req with 32'h2008_0005.
  - Required: mem_req cycles 1–1, mem_we=0, if_ready at cycle 2 with if_rdata=32'h2008_0005, d_ready=0 throughout.
- Store:
  - Stimulus: d_req=1, d_we=1, d_addr=32'h54, d_wdata=32'h7, ack delayed 3 cycles.
  - Required: mem_we=1 and mem_addr/mem_wdata stable for 3 cycles; d_ready pulses once, the cycle after ack.
- Collision:
  - Stimulus: if_req and d_req rise in the same cycle.
  - Required: data granted first; fetch granted at cycle k+2 after the data ready; no double grant while in DONE.
- Starvation, FETCH_STARVE=4:
  - Stimulus: d_req held continuously with re-requests, if_req held.
  - Required: exactly 4 data grants, then a fetch grant, and starve_cnt returns to 0.
- Timeout, TIMEOUT=8:
  - Stimulus: mem_ack never asserted on a data read.
  - Required: mem_req drops after 8 cycles; d_ready=1, err=1 and d_rdata=32'hDEADBEEF for one cycle. A subsequent ack is ignored.
- Mid-access reset:
  - Stimulus: assert reset while in BUSY_I.
  - Required: next cycle mem_req=0, all ready outputs 0, state IDLE. A stale mem_ack afterwards produces no ready pulse.
